// File: rtl/graph_mem_pkg.sv
// Shared types and default widths for the graph pipeline memory stages.
// Holds the arbiter state encoding and the memory operation type.
package graph_mem_pkg;

    localparam int unsigned GRAPH_NUM_REQ = 4;
    localparam int unsigned GRAPH_ADDR_W  = 64;
    localparam int unsigned GRAPH_DATA_W  = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_e;

    typedef enum logic {
        MEM_OP_READ,
        MEM_OP_WRITE
    } mem_op_e;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Rotate-priority select: first set bit of req_vec after ptr, wrapping.
// Ports: req_vec (requests), ptr (last grant) -> any (hit), idx (winner).
module rr_picker
    import graph_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_vec,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest hit after ptr wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req_vec[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_REQ stages, round-robin, one in flight.
// Ports: req_* per-requester side, mem_* memory side, grant_id/busy/proto_err status.
module mem_port_arbiter
    import graph_mem_pkg::*;
#(
    parameter int NUM_REQ    = GRAPH_NUM_REQ,
    parameter int addr_width = GRAPH_ADDR_W,
    parameter int data_width = GRAPH_DATA_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_read,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*addr_width-1:0]   req_addr,
    input  logic [NUM_REQ*data_width-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_resp,
    output logic [data_width-1:0]           req_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [addr_width-1:0]           mem_addr,
    output logic [data_width-1:0]           mem_wdata,
    input  logic                            mem_resp,
    input  logic [data_width-1:0]           mem_rdata,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            proto_err
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e              state_q;
    arb_state_e              state_d;
    logic [IW-1:0]           grant_q;
    logic [IW-1:0]           rr_ptr_q;
    mem_op_e                 op_q;
    logic [addr_width-1:0]   addr_q;
    logic [data_width-1:0]   wdata_q;
    logic [data_width-1:0]   rdata_q;
    logic                    err_q;

    logic                    pick_any;
    logic [IW-1:0]           pick_idx;
    logic                    sel_read;
    logic                    sel_write;
    logic [addr_width-1:0]   sel_addr;
    logic [data_width-1:0]   sel_wdata;
    logic                    take;
    logic                    in_busy;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_vec (req_read | req_write),
        .ptr     (rr_ptr_q),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    always_comb begin
        sel_read  = req_read[pick_idx];
        sel_write = req_write[pick_idx];
        sel_addr  = req_addr[int'(pick_idx)*addr_width +: addr_width];
        sel_wdata = req_wdata[int'(pick_idx)*data_width +: data_width];
    end

    assign take    = (state_q == ARB_IDLE) && pick_any;
    assign in_busy = (state_q == ARB_BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (pick_any) state_d = ARB_BUSY;
            ARB_BUSY: if (mem_resp) state_d = ARB_DONE;
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // A read+write collision resolves to a read, so wdata is zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q  <= '0;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            op_q     <= MEM_OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (take) begin
                grant_q  <= pick_idx;
                rr_ptr_q <= pick_idx;
                op_q     <= sel_read ? MEM_OP_READ : MEM_OP_WRITE;
                addr_q   <= sel_addr;
                wdata_q  <= sel_read ? '0 : sel_wdata;
            end
            if (in_busy && mem_resp) begin
                rdata_q <= mem_rdata;
            end
            if ((take && sel_read && sel_write) ||
                (mem_resp && !in_busy)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_resp = '0;
        if (state_q == ARB_DONE) begin
            req_resp[grant_q] = 1'b1;
        end
    end

    assign mem_read  = in_busy && (op_q == MEM_OP_READ);
    assign mem_write = in_busy && (op_q == MEM_OP_WRITE);
    assign mem_addr  = in_busy ? addr_q : '0;
    assign mem_wdata = in_busy ? wdata_q : '0;
    assign req_rdata = rdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ARB_IDLE);
    assign proto_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      req_resp;
    logic [DW-1:0]     req_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_resp = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic              proto_err;

    mem_port_arbiter #(
        .NUM_REQ    (N),
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_read  (req_read),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_resp  (req_resp),
        .req_rdata (req_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_resp  (mem_resp),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = memory access, 2 = completion.
    int            m_phase = 0;
    int            m_grant = 0;
    int            m_last = N - 1;
    bit            m_write = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 0;
    bit            m_freed_v = 0;
    int            m_freed = 0;
    int            wait_cnt[N];

    always @(posedge clk or negedge rst) begin
        int  pick;
        bit  rd;
        bit  wr;
        pick = -1;
        if (!rst) begin
            m_phase = 0; m_grant = 0; m_last = N - 1;
            m_write = 0; m_addr = '0; m_wdata = '0;
            m_rdata = '0; m_err = 0; m_freed_v = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            m_freed_v = 0;
            if (m_phase == 0) begin
                if (mem_resp) m_err = 1;
                for (int k = N; k >= 1; k--) begin
                    if (req_read[(m_last + k) % N] ||
                        req_write[(m_last + k) % N])
                        pick = (m_last + k) % N;
                end
                if (pick >= 0) begin
                    rd = req_read[pick];
                    wr = req_write[pick];
                    chk("fair_wait", 64'(wait_cnt[pick] <= N - 1), 64'd1);
                    for (int i = 0; i < N; i++)
                        if (i != pick && (req_read[i] || req_write[i]))
                            wait_cnt[i]++;
                    wait_cnt[pick] = 0;
                    if (rd && wr) m_err = 1;
                    m_grant = pick;
                    m_last  = pick;
                    m_write = wr && !rd;
                    m_addr  = req_addr[pick*AW +: AW];
                    m_wdata = m_write ? req_wdata[pick*DW +: DW] : '0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_resp) begin
                    m_rdata = mem_rdata;
                    m_phase = 2;
                end
            end else begin
                if (mem_resp) m_err = 1;
                m_freed_v = 1;
                m_freed   = m_grant;
                m_phase   = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_phase != 0));
        chk("mem_read", 64'(mem_read), 64'(m_phase == 1 && !m_write));
        chk("mem_write", 64'(mem_write), 64'(m_phase == 1 && m_write));
        chk("mem_addr", mem_addr, (m_phase == 1) ? m_addr : 64'd0);
        chk("mem_wdata", mem_wdata, (m_phase == 1) ? m_wdata : 64'd0);
        chk("req_resp", 64'(req_resp),
            (m_phase == 2) ? (64'd1 << m_grant) : 64'd0);
        chk("req_rdata", req_rdata, m_rdata);
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        chk("proto_err", 64'(proto_err), 64'(m_err));
    end

    // Memory responder: answers after lat access cycles.
    int            lat = 1;
    int            cur_lat = 1;
    bit            lat_rand = 0;
    bit            spur_en = 0;
    bit            spur_req = 0;
    bit            use_fixed = 0;
    logic [DW-1:0] fixed_rd = '0;
    int            bcnt = 0;

    always @(posedge clk) begin
        #1;
        if (m_phase == 1) begin
            bcnt++;
            if (bcnt == 1)
                cur_lat = lat_rand ? int'($urandom_range(1, 4)) : lat;
            mem_resp  = (bcnt >= cur_lat);
            mem_rdata = use_fixed ? fixed_rd : {$urandom, $urandom};
        end else begin
            bcnt      = 0;
            mem_resp  = spur_req || (spur_en && $urandom_range(0, 7) == 0);
            spur_req  = 0;
            mem_rdata = {$urandom, $urandom};
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[i]            = rd;
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        req_read  = '0;
        req_write = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_reqs();
        step(2);
        rst = 1'b1;
    endtask

    task automatic wait_mem(input string name, input int budget);
        int c;
        c = 0;
        while (!(mem_read || mem_write) && c < budget) begin
            step(1);
            c++;
        end
        if (!(mem_read || mem_write)) chk(name, 64'd0, 64'd1);
    endtask

    task automatic wait_resp(output int idx, input int budget);
        int c;
        idx = -1;
        c   = 0;
        while (req_resp == '0 && c < budget) begin
            step(1);
            c++;
        end
        for (int i = 0; i < N; i++) if (req_resp[i]) idx = i;
        if (idx < 0) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        int n;
        int rr_exp[6];
        int b2b_exp[3];
        rr_exp  = '{0, 1, 2, 3, 0, 1};
        b2b_exp = '{0, 3, 0};

        // Reset state
        do_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_err", 64'(proto_err), 64'd0);
        chk("rst_resp", 64'(req_resp), 64'd0);

        // Single read
        lat = 3; use_fixed = 1; fixed_rd = 64'hDEAD;
        set_req(2, 1, 0, 64'h40, 64'h0);
        wait_mem("t1_strobe", 10);
        chk("t1_addr", mem_addr, 64'h40);
        n = 0;
        while (req_resp == '0 && n < 10) begin
            step(1);
            n++;
        end
        chk("t1_latency", 64'(n), 64'd3);
        chk("t1_resp", 64'(req_resp), 64'b0100);
        chk("t1_rdata", req_rdata, 64'hDEAD);
        chk("t1_grant", 64'(grant_id), 64'd2);
        step(1);
        set_req(2, 0, 0, 64'h0, 64'h0);
        chk("t1_pulse", 64'(req_resp), 64'd0);
        use_fixed = 0;

        // Round-robin with all requesters holding
        do_reset();
        lat = 1;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 64'(i * 16), 64'h0);
        for (int g = 0; g < 6; g++) begin
            wait_resp(idx, 20);
            chk("rr_order", 64'(idx), 64'(rr_exp[g]));
            step(1);
        end
        clear_reqs();
        step(3);

        // Write path
        do_reset();
        lat = 3;
        set_req(1, 0, 1, 64'h100, 64'hCAFE);
        wait_mem("wr_strobe", 10);
        n = 0;
        while (mem_write && n < 10) begin
            chk("wr_wdata", mem_wdata, 64'hCAFE);
            chk("wr_addr", mem_addr, 64'h100);
            chk("wr_noread", 64'(mem_read), 64'd0);
            step(1);
            n++;
        end
        chk("wr_cycles", 64'(n), 64'd3);
        chk("wr_resp", 64'(req_resp), 64'b0010);
        step(1);
        clear_reqs();
        step(2);

        // Back-to-back: 0 re-asserts while 3 waits
        do_reset();
        lat = 2;
        set_req(0, 1, 0, 64'h8, 64'h0);
        wait_mem("b2b_strobe", 10);
        set_req(3, 1, 0, 64'h18, 64'h0);
        for (int g = 0; g < 3; g++) begin
            wait_resp(idx, 20);
            chk("b2b_order", 64'(idx), 64'(b2b_exp[g]));
            if (idx == 3) set_req(3, 0, 0, 64'h0, 64'h0);
            step(1);
        end
        clear_reqs();
        step(3);

        // Spurious response in idle
        do_reset();
        spur_req = 1;
        step(4);
        chk("spur_err", 64'(proto_err), 64'd1);
        do_reset();
        chk("spur_clear", 64'(proto_err), 64'd0);

        // Read and write together
        set_req(0, 1, 1, 64'h80, 64'h55);
        wait_mem("rw_strobe", 10);
        chk("rw_read", 64'(mem_read), 64'd1);
        chk("rw_nowrite", 64'(mem_write), 64'd0);
        chk("rw_wdata", mem_wdata, 64'd0);
        chk("rw_err", 64'(proto_err), 64'd1);
        wait_resp(idx, 10);
        step(1);
        clear_reqs();
        spur_req = 1;
        step(6);
        chk("rw_sticky", 64'(proto_err), 64'd1);
        do_reset();
        chk("rw_clear", 64'(proto_err), 64'd0);

        // Reset in the middle of an access
        lat = 20;
        set_req(0, 1, 0, 64'h200, 64'h0);
        wait_mem("mid_strobe", 10);
        step(1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_read", 64'(mem_read), 64'd0);
        chk("mid_write", 64'(mem_write), 64'd0);
        chk("mid_addr", mem_addr, 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_resp", 64'(req_resp), 64'd0);
        chk("mid_grant", 64'(grant_id), 64'd0);
        chk("mid_rdata", req_rdata, 64'd0);
        clear_reqs();
        step(2);
        rst = 1'b1;
        lat = 1;
        set_req(2, 1, 0, 64'h300, 64'h0);
        set_req(0, 1, 0, 64'h200, 64'h0);
        wait_resp(idx, 10);
        chk("mid_first", 64'(idx), 64'd0);
        step(1);
        clear_reqs();
        step(4);

        // Random traffic
        do_reset();
        lat_rand = 1;
        spur_en  = 1;
        for (int c = 0; c < 1500; c++) begin
            if (m_freed_v) set_req(m_freed, 0, 0, 64'h0, 64'h0);
            for (int i = 0; i < N; i++) begin
                if (!(req_read[i] || req_write[i]) &&
                    !(m_phase != 0 && m_grant == i) &&
                    !(m_freed_v && m_freed == i && $urandom_range(0, 1) == 0) &&
                    $urandom_range(0, 2) == 0) begin
                    n = int'($urandom_range(0, 19));
                    set_req(i, n < 11, n == 0 || n >= 11,
                            {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
            step(1);
        end
        spur_en = 0;
        clear_reqs();
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
